// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch stage: state encodings, control-flow opcodes, nop word.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        FS_BOOT   = 2'b00,
        FS_RUN    = 2'b01,
        FS_HALTED = 2'b10
    } fetch_state_e;

    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational control-flow predecode; gated by run_en so nothing is flagged outside RUN.
module fetch_predecode
    import fetch_pc_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       run_en,
    output logic       is_jump_or_branch
);

    assign is_jump_or_branch = run_en &&
        ((opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH));

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, IF/ID register and boot/run/halt sequencing.
// Optional FETCH_STATS_EN adds saturating fetch/flush counters.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] predict_PC,
    input  logic        is_flush,
    input  logic        stall,
    input  logic        halt,
    input  logic [31:0] imem_dout,
    output logic [31:0] current_PC,
    output logic        current_is_jump_or_branch,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_PC,
    output logic [31:0] if_id_pred_PC,
    output logic        if_id_valid,
    output logic [1:0]  fetch_state
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushes
`endif
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_e state, state_nxt;
    logic [3:0]   boot_cnt, boot_cnt_nxt;
    logic         run_en, pc_ld, adv, flush, kill;
    logic [31:0]  next_pc;
    logic         unused_pc_lsbs;

    // The PC is word-aligned by construction; BTB low bits are dropped here.
    assign next_pc        = {predict_PC[31:2], 2'b00};
    assign unused_pc_lsbs = ^predict_PC[1:0];
    assign fetch_state    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FS_BOOT;
            boot_cnt <= '0;
        end else begin
            state    <= state_nxt;
            boot_cnt <= boot_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        boot_cnt_nxt = boot_cnt;
        run_en       = 1'b0;
        pc_ld        = 1'b0;
        adv          = 1'b0;
        flush        = 1'b0;
        kill         = 1'b0;
        case (state)
            FS_BOOT: begin
                boot_cnt_nxt = boot_cnt + 4'd1;
                if (boot_cnt == BOOT_LAST) state_nxt = FS_RUN;
            end
            FS_RUN: begin
                run_en = 1'b1;
                if (halt) begin
                    state_nxt = FS_HALTED;
                    kill      = 1'b1;
                end else if (is_flush) begin
                    pc_ld = 1'b1;
                    flush = 1'b1;
                end else if (!stall) begin
                    pc_ld = 1'b1;
                    adv   = 1'b1;
                end
            end
            FS_HALTED: ;
            default: state_nxt = FS_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_PC    <= RESET_PC;
            if_id_inst    <= NOP_INST;
            if_id_PC      <= '0;
            if_id_pred_PC <= '0;
            if_id_valid   <= 1'b0;
        end else begin
            if (pc_ld) current_PC <= next_pc;
            if (adv) begin
                if_id_inst    <= imem_dout;
                if_id_PC      <= current_PC;
                if_id_pred_PC <= next_pc;
                if_id_valid   <= 1'b1;
            end else if (flush) begin
                if_id_inst  <= NOP_INST;
                if_id_valid <= 1'b0;
            end else if (kill) begin
                if_id_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetched <= '0;
            stat_flushes <= '0;
        end else begin
            if (adv && (stat_fetched != '1))   stat_fetched <= stat_fetched + 32'd1;
            if (flush && (stat_flushes != '1)) stat_flushes <= stat_flushes + 32'd1;
        end
    end
`endif

    fetch_predecode u_predecode (
        .opcode            (imem_dout[6:0]),
        .run_en            (run_en),
        .is_jump_or_branch (current_is_jump_or_branch)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; stats checks are compiled in with FETCH_STATS_EN.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] predict_PC;
    logic        is_flush, stall, halt;
    logic [31:0] imem_dout;
    logic [31:0] current_PC, if_id_inst, if_id_PC, if_id_pred_PC;
    logic        current_is_jump_or_branch, if_id_valid;
    logic [1:0]  fetch_state;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_flushes;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(32'h0), .BOOT_CYCLES(2)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .predict_PC                (predict_PC),
        .is_flush                  (is_flush),
        .stall                     (stall),
        .halt                      (halt),
        .imem_dout                 (imem_dout),
        .current_PC                (current_PC),
        .current_is_jump_or_branch (current_is_jump_or_branch),
        .if_id_inst                (if_id_inst),
        .if_id_PC                  (if_id_PC),
        .if_id_pred_PC             (if_id_pred_PC),
        .if_id_valid               (if_id_valid),
        .fetch_state               (fetch_state)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched              (stat_fetched),
        .stat_flushes              (stat_flushes)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                         input logic fl, input logic st, input logic hl);
        predict_PC = pc;
        imem_dout  = inst;
        is_flush   = fl;
        stall      = st;
        halt       = hl;
    endtask

    task automatic boot();
        @(negedge clk);
        reset = 1'b1;
        chk("boot_st0", 32'(fetch_state), 32'h0);
        step();
        chk("boot_st1", 32'(fetch_state), 32'h0);
        chk("boot_pc", current_PC, 32'h0);
        step();
        chk("boot_run", 32'(fetch_state), 32'h1);
        chk("boot_vld", 32'(if_id_valid), 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        drive(32'h0, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", current_PC, 32'h0);
        chk("rst_inst", if_id_inst, 32'h0000_0013);
        chk("rst_ifpc", if_id_PC, 32'h0);
        chk("rst_pred", if_id_pred_PC, 32'h0);
        chk("rst_vld", 32'(if_id_valid), 32'h0);
        chk("rst_st", 32'(fetch_state), 32'h0);

        // JAL seen during BOOT must not be flagged
        imem_dout = 32'h0000_006F;
        #1 chk("pd_boot_jal", 32'(current_is_jump_or_branch), 32'h0);
        imem_dout = 32'h0000_0013;
        boot();

        // sequential fetch 0,4,8,C
        drive(32'h4, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        #1 chk("pd_nop", 32'(current_is_jump_or_branch), 32'h0);
        step();
        chk("a1_vld", 32'(if_id_valid), 32'h1);
        chk("a1_ifpc", if_id_PC, 32'h0);
        chk("a1_pred", if_id_pred_PC, 32'h4);
        chk("a1_pc", current_PC, 32'h4);

        drive(32'h8, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
        #1 chk("pd_add", 32'(current_is_jump_or_branch), 32'h0);
        step();
        chk("a2_pc", current_PC, 32'h8);
        chk("a2_ifpc", if_id_PC, 32'h4);
        chk("a2_inst", if_id_inst, 32'h0000_0033);

        drive(32'hC, 32'h0000_006F, 1'b0, 1'b0, 1'b0);
        #1 chk("pd_jal", 32'(current_is_jump_or_branch), 32'h1);
        step();
        chk("a3_pc", current_PC, 32'hC);
        chk("a3_ifpc", if_id_PC, 32'h8);
        chk("a3_pred", if_id_pred_PC, 32'hC);

        drive(32'h10, 32'h0000_0063, 1'b0, 1'b0, 1'b0);
        #1 chk("pd_br", 32'(current_is_jump_or_branch), 32'h1);
        step();
        chk("a4_pc", current_PC, 32'h10);
        chk("a4_inst", if_id_inst, 32'h0000_0063);

        // stall: everything frozen at PC 0x10
        drive(32'h80, 32'h0000_0067, 1'b0, 1'b1, 1'b0);
        #1 chk("pd_jalr", 32'(current_is_jump_or_branch), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_pc", current_PC, 32'h10);
            chk("st_ifpc", if_id_PC, 32'hC);
            chk("st_inst", if_id_inst, 32'h0000_0063);
            chk("st_pred", if_id_pred_PC, 32'h10);
            chk("st_vld", 32'(if_id_valid), 32'h1);
        end

        // flush overrides stall
        drive(32'h40, 32'h0000_0013, 1'b1, 1'b1, 1'b0);
        step();
        chk("fl_pc", current_PC, 32'h40);
        chk("fl_vld", 32'(if_id_valid), 32'h0);
        chk("fl_inst", if_id_inst, 32'h0000_0013);

        // misaligned target is word-aligned
        drive(32'h46, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
        step();
        chk("mis_pc", current_PC, 32'h44);
        chk("mis_ifpc", if_id_PC, 32'h40);
        chk("mis_vld", 32'(if_id_valid), 32'h1);

        drive(32'h20, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
        step();
        chk("fl2_pc", current_PC, 32'h20);
        chk("fl2_vld", 32'(if_id_valid), 32'h0);

        // halt wins over flush
        drive(32'h98, 32'h0000_0013, 1'b1, 1'b0, 1'b1);
        step();
        chk("h_st", 32'(fetch_state), 32'h2);
        chk("h_pc", current_PC, 32'h20);
        chk("h_vld", 32'(if_id_valid), 32'h0);
`ifdef FETCH_STATS_EN
        chk("stat_fetch", stat_fetched, 32'd5);
        chk("stat_flush", stat_flushes, 32'd2);
`endif
        drive(32'h30, 32'h0000_006F, 1'b0, 1'b0, 1'b0);
        #1 chk("pd_halt_jal", 32'(current_is_jump_or_branch), 32'h0);
        repeat (2) step();
        chk("h2_st", 32'(fetch_state), 32'h2);
        chk("h2_pc", current_PC, 32'h20);
        chk("h2_vld", 32'(if_id_valid), 32'h0);

        // async reset in the middle of a cycle
        drive(32'h30, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("ar_st", 32'(fetch_state), 32'h0);
        chk("ar_pc", current_PC, 32'h0);
        chk("ar_inst", if_id_inst, 32'h0000_0013);
`ifdef FETCH_STATS_EN
        chk("ar_stat", stat_fetched, 32'd0);
`endif
        stall = 1'b0;
        boot();

        // wrap past the top of the address space
        drive(32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        step();
        chk("w1_pc", current_PC, 32'hFFFF_FFFC);
        drive(32'h0, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
        step();
        chk("w2_pc", current_PC, 32'h0);
        chk("w2_ifpc", if_id_PC, 32'hFFFF_FFFC);
        chk("w2_pred", if_id_pred_PC, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
